modred_arbiter: RTL and testbench

MODRED_ARBITER -- requirements
Module: modred_arbiter

---
 rtl/modred_arbiter.sv | 109 ++++++++++
 tb/tb_modred_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/modred_arbiter.sv
// Round-robin front end for a shared combinational modulo-65537 unit.
// Two-stage pipeline: operand stage A feeds the unit, stage R holds results.
module modred_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      mod_in,
  input  logic [WIDTH-1:0]      mod_out,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [1:0]            rsp_id,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [15:0]           op_count
);

  logic             a_v;
  logic [WIDTH-1:0] a_data;
  logic [1:0]       a_id;
  logic             r_v;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_id;
  logic [1:0]       last_gnt;

  logic             r_free;
  logic             a_free;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [NREQ-1:0]  gnt_oh;
  logic             fire;
  logic [WIDTH-1:0] sel;

  assign r_free = !r_v | rsp_ready;
  assign a_free = !a_v | (a_v & r_free);

  // First valid requester after last_gnt, wrapping modulo 4
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_gnt + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    unique case (1'b1)
      (win == 2'd0): gnt_oh[0] = 1'b1;
      (win == 2'd1): gnt_oh[1] = 1'b1;
      (win == 2'd2): gnt_oh[2] = 1'b1;
      default:       gnt_oh[3] = 1'b1;
    endcase
  end

  // rst_n gate keeps req_ready low while reset is held
  assign req_ready = (rst_n && found && a_free) ? gnt_oh : '0;
  assign fire      = |(req_valid & req_ready);
  assign sel       = req_data[int'(win)*WIDTH +: WIDTH];

  assign mod_in    = a_v ? a_data : '0;
  assign rsp_valid = r_v;
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;
  assign busy      = a_v | r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v      <= 1'b0;
      a_data   <= '0;
      a_id     <= '0;
      r_v      <= 1'b0;
      r_data   <= '0;
      r_id     <= '0;
      last_gnt <= 2'd3;
      op_count <= '0;
    end else begin
      if (a_free) begin
        a_v <= fire;
        if (fire) begin
          a_data <= sel;
          a_id   <= win;
        end
      end
      if (fire)
        last_gnt <= win;
      if (r_free) begin
        r_v <= a_v;
        if (a_v) begin
          r_data <= mod_out;
          r_id   <= a_id;
        end
      end
      if (r_v && rsp_ready)
        op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_modred_arbiter.sv
// Directed bench for modred_arbiter with a reference modulo unit
// and a queue scoreboard of expected (id, result) pairs.
module tb_modred_arbiter;

  localparam int W = 32;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req_valid = '0;
  logic [4*W-1:0] req_data = '0;
  logic [3:0]     req_ready;
  logic [W-1:0]   mod_in;
  logic [W-1:0]   mod_out;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ready = 1'b0;
  logic           busy;
  logic [15:0]    op_count;

  int   total = 0;
  int   bad = 0;
  int   ntx = 0;
  bit   oneshot = 0;
  exp_t sb[$];
  logic [1:0] gnt_log[$];

  modred_arbiter #(.WIDTH(W), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .mod_in(mod_in), .mod_out(mod_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .op_count(op_count)
  );

  assign mod_out = mod_in % 32'd65537;

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0] clr;
    exp_t e;
    clr = '0;
    #1;
    check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = 2'(i);
        e.data = req_data[i*W +: W] % 32'd65537;
        sb.push_back(e);
        gnt_log.push_back(2'(i));
        ntx++;
        clr[i] = 1'b1;
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", rsp_data, e.data);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (oneshot)
      req_valid = req_valid & ~clr;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((sb.size() > 0 || req_valid != '0) && n < limit) begin
      step();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    gnt_log.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};

    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_mod_in", mod_in, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single operation from requester 2
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_data[2*W +: W] = 32'd131073;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_data", rsp_data, 32'd65536);
    check("single_rsp_id", 32'(rsp_id), 32'd2);
    check("single_cnt_before", 32'(op_count), 32'd0);
    step();
    check("single_op_count", 32'(op_count), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // round robin from reset
    pulse_reset();
    req_data[0*W +: W] = 32'd65536;
    req_data[1*W +: W] = 32'd65538;
    req_data[2*W +: W] = 32'd7;
    req_data[3*W +: W] = 32'd0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    check("rr_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      check("rr_gnt", 32'(gnt_log[i]), 32'(exp_rr[i]));
    check("rr_throughput", 32'(op_count), 32'd3);
    req_valid = '0;
    drain(10);
    check("rr_done_cnt", 32'(op_count), 32'd5);

    // reset mid-stream with both stages full
    pulse_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    check("mid_op_count", 32'(op_count), 32'd0);
    check("mid_mod_in", mod_in, 32'd0);
    @(negedge clk);
    sb.delete();
    gnt_log.delete();
    rst_n = 1'b1;
    step();
    check("mid_first_gnt", 32'(gnt_log.size() > 0 ? gnt_log[0] : 2'd3), 32'd0);
    req_valid = '0;
    drain(10);

    // backpressure: last_gnt is 0, so 1 wins before 3
    gnt_log.delete();
    rsp_ready = 1'b0;
    req_data[1*W +: W] = 32'd100000;
    req_data[3*W +: W] = 32'd5;
    req_valid = 4'b1010;
    step();
    req_valid = 4'b1000;
    step();
    req_data[3*W +: W] = 32'd70000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_rsp_data", rsp_data, 32'd34463);
      check("bp_rsp_id", 32'(rsp_id), 32'd1);
      check("bp_mod_in", mod_in, 32'd5);
      step();
    end
    check("bp_gnts", 32'(gnt_log.size()), 32'd2);
    rsp_ready = 1'b1;
    oneshot = 1;
    drain(20);
    oneshot = 0;
    check("bp_gnts_all", 32'(gnt_log.size()), 32'd3);

    // counter wrap over 65536 responses
    pulse_reset();
    ntx = 0;
    req_valid = 4'b0001;
    while (ntx < 65536) begin
      req_data[0*W +: W] = 32'(ntx) * 32'd40503;
      step();
      gnt_log.delete();
    end
    req_valid = '0;
    check("wrap_sb_pending", 32'(sb.size()), 32'd2);
    step();
    check("wrap_cnt_ffff", 32'(op_count), 32'hffff);
    check("wrap_busy_last", 32'(busy), 32'd1);
    step();
    check("wrap_cnt_zero", 32'(op_count), 32'd0);
    check("wrap_busy_drop", 32'(busy), 32'd0);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
